// File: rtl/hotcache_fill_ctrl_if.sv
// rtl/hotcache_fill_ctrl_if.sv - load, hot cache, CRB, memory and counter signals of the fill controller
//
// Purpose: bundles every non-clock/reset signal of hotcache_fill_ctrl.
//   slave  modport : the fill controller itself
//   master modport : the surrounding issue stage, hot cache, CRB and memory
// Signal groups:
//   ld_req_*  : load request from the issue stage (valid/ready)
//   ld_resp_* : load response to the consumer (valid/ready)
//   hc_rd_*   : combinational hot cache probe
//   hc_cmd_*  : hot cache fill strobe and payload
//   crb_*     : Common Result Bus commit snoop
//   mem_*     : memory read request (valid/ready) and single-cycle response
//   *_count   : perf counters
interface hotcache_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              ld_req_valid;
    logic              ld_req_ready;
    logic [2:0]        ld_req_reg;
    logic [15:0]       ld_req_offset;
    logic [ADDR_W-1:0] ld_req_addr;

    logic              ld_resp_valid;
    logic              ld_resp_ready;
    logic [DATA_W-1:0] ld_resp_data;
    logic              ld_resp_hit;

    logic              flush;

    logic [2:0]        hc_rd_reg;
    logic [15:0]       hc_rd_offset;
    logic [DATA_W-1:0] hc_rd_data;
    logic              hc_rd_cached;

    logic              hc_cmd_cache;
    logic [2:0]        hc_cmd_reg;
    logic [15:0]       hc_cmd_offset;
    logic [DATA_W-1:0] hc_cmd_data;

    logic [2:0]        crb_reg;
    logic              crb_commit;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic [15:0]       hit_count;
    logic [15:0]       miss_count;

    modport slave (
        input  ld_req_valid, ld_req_reg, ld_req_offset, ld_req_addr,
        output ld_req_ready,
        output ld_resp_valid, ld_resp_data, ld_resp_hit,
        input  ld_resp_ready,
        input  flush,
        output hc_rd_reg, hc_rd_offset,
        input  hc_rd_data, hc_rd_cached,
        output hc_cmd_cache, hc_cmd_reg, hc_cmd_offset, hc_cmd_data,
        input  crb_reg, crb_commit,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output hit_count, miss_count
    );

    modport master (
        output ld_req_valid, ld_req_reg, ld_req_offset, ld_req_addr,
        input  ld_req_ready,
        input  ld_resp_valid, ld_resp_data, ld_resp_hit,
        output ld_resp_ready,
        output flush,
        input  hc_rd_reg, hc_rd_offset,
        output hc_rd_data, hc_rd_cached,
        input  hc_cmd_cache, hc_cmd_reg, hc_cmd_offset, hc_cmd_data,
        output crb_reg, crb_commit,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/hotcache_fill_ctrl.sv
// rtl/hotcache_fill_ctrl.sv - load sequencer with hot cache probe, memory miss path and guarded fill
//
// Purpose: takes one load at a time, answers it from the hot cache on a hit,
//   otherwise reads memory and fills the hot cache when the [reg, offset]
//   pattern is cacheable and no CRB commit to the same base register has
//   made the fetched value stale. Counts hits and misses.
// Ports:
//   clk   : clock
//   a_rst : synchronous active-high reset
//   bus   : hotcache_fill_ctrl_if.slave (load request/response, hot cache
//           probe and fill, CRB snoop, memory read, perf counters)
module hotcache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  a_rst,
    hotcache_fill_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_reg;
    logic [15:0]       r_off;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_hit;
    logic              r_cacheable;
    logic              r_taint;
    logic              r_dropped;
    logic              r_fill_pend;
    logic [15:0]       r_hit_cnt;
    logic [15:0]       r_miss_cnt;

    logic              w_idle;
    logic              w_accept;
    logic              w_crb_hit;
    logic              w_req_cacheable;

    assign w_idle   = (r_state == IDLE);
    // A flush in IDLE withholds ready so the issue stage never sees a handshake
    // that was not taken.
    assign w_accept = w_idle & bus.ld_req_valid & ~bus.flush;

    // Only reg[2]=1 registers can be cached, so matching the low two bits on
    // top of crb_reg[2] identifies the same base register.
    assign w_crb_hit = bus.crb_commit & bus.crb_reg[2] &
                       (bus.crb_reg[1:0] == r_reg[1:0]);

    assign w_req_cacheable = bus.ld_req_reg[2] &
                             (bus.ld_req_offset[15:4] == 12'd0) &
                             ~bus.ld_req_offset[0];

    // Probe with the live request in IDLE so hit/miss is known at acceptance.
    assign bus.hc_rd_reg    = w_idle ? bus.ld_req_reg    : r_reg;
    assign bus.hc_rd_offset = w_idle ? bus.ld_req_offset : r_off;

    assign bus.ld_req_ready  = w_idle & ~bus.flush;
    // Flush in RESP drops the response and any fill not yet issued.
    assign bus.ld_resp_valid = (r_state == RESP) & ~bus.flush;
    assign bus.ld_resp_data  = r_data;
    assign bus.ld_resp_hit   = r_hit;

    assign bus.hc_cmd_cache  = (r_state == RESP) & r_fill_pend & ~bus.flush;
    assign bus.hc_cmd_reg    = r_reg;
    assign bus.hc_cmd_offset = r_off;
    assign bus.hc_cmd_data   = r_data;

    assign bus.mem_req_valid = (r_state == MREQ);
    assign bus.mem_req_addr  = r_addr;

    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_state     <= IDLE;
            r_reg       <= '0;
            r_off       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_hit       <= 1'b0;
            r_cacheable <= 1'b0;
            r_taint     <= 1'b0;
            r_dropped   <= 1'b0;
            r_fill_pend <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_reg       <= bus.ld_req_reg;
                        r_off       <= bus.ld_req_offset;
                        r_addr      <= bus.ld_req_addr;
                        r_cacheable <= w_req_cacheable;
                        r_taint     <= 1'b0;
                        r_dropped   <= 1'b0;
                        r_fill_pend <= 1'b0;
                        if (bus.hc_rd_cached) begin
                            r_data    <= bus.hc_rd_data;
                            r_hit     <= 1'b1;
                            r_hit_cnt <= r_hit_cnt + 16'd1;
                            r_state   <= RESP;
                        end else begin
                            r_hit      <= 1'b0;
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                            r_state    <= MREQ;
                        end
                    end
                end

                MREQ: begin
                    if (w_crb_hit) begin
                        r_taint <= 1'b1;
                    end
                    // The request handshake must still complete after a flush;
                    // the returning data is discarded later.
                    if (bus.flush) begin
                        r_dropped <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        r_state <= MWAIT;
                    end
                end

                MWAIT: begin
                    if (w_crb_hit) begin
                        r_taint <= 1'b1;
                    end
                    if (bus.flush) begin
                        r_dropped <= 1'b1;
                    end
                    if (bus.mem_resp_valid) begin
                        if (r_dropped | bus.flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_data      <= bus.mem_resp_data;
                            r_hit       <= 1'b0;
                            // Include a commit landing in the same cycle as the data.
                            r_fill_pend <= r_cacheable & ~(r_taint | w_crb_hit);
                            r_state     <= RESP;
                        end
                    end
                end

                RESP: begin
                    // The fill strobe lives for the first RESP cycle only.
                    r_fill_pend <= 1'b0;
                    if (bus.flush | bus.ld_resp_ready) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
